merge_queue: RTL and testbench
==============================

MERGE_QUEUE -- requirements
Module: merge_queue

Interface
REQ-001 Parameter NUM_PORT, default 5, SHALL set the number of input ports.
REQ-002 Parameter DEPTH, default 4, min 2, SHALL set the number of buffered entries.
REQ-003 Parameters ADDR_W (default `MEM_ADDR_WIDTH), DST_W (`DST_WIDTH) and SRC_W (`SRC_LIST_WIDTH) SHALL set the field widths.
REQ-004 clk  in  1  the single clock; all state SHALL be updated on its rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 in_valid  in  NUM_PORT  per-port request valid.
REQ-007 in_type  in  NUM_PORT  per-port request type bit.
REQ-008 in_addr  in  NUM_PORT*ADDR_W  per-port memory address, packed with port 0 in the LSBs.
REQ-009 in_dst  in  NUM_PORT*DST_W  per-port destination, packed.
REQ-010 in_src  in  NUM_PORT*SRC_W  per-port source list (one-hot or multi-hot), packed.
REQ-011 in_accept  out  NUM_PORT  request absorbed this cycle, by merge or by allocation (combinational).
REQ-012 kill  out  NUM_PORT  request absorbed by merge; the upstream flit is dropped (combinational; kill implies in_accept).
REQ-013 out_valid, out_type, out_addr, out_dst, out_src  out  1/1/ADDR_W/DST_W/SRC_W  the head entry.
REQ-014 out_ready  in  1  downstream accepts the head entry.
REQ-015 count  out  $clog2(DEPTH+1)  number of valid entries.

Function
REQ-016 A key SHALL be the tuple {type, addr, dst}; two requests match when all three fields are equal.
REQ-017 A valid input matching a valid stored entry SHALL assert kill and in_accept, and OR its src into the lowest-index matching entry at the next edge.
REQ-018 The head entry SHALL be excluded from matching in any cycle with out_valid && out_ready.
REQ-019 Several inputs merging into the same entry in one cycle SHALL all be killed, with all their src lists ORed in.
REQ-020 Same-cycle input-to-input match with no stored match: the lowest port SHALL allocate, and each higher matching port SHALL be killed with its src ORed into that new entry.
REQ-021 Remaining unmatched inputs SHALL allocate free entries in ascending port order at the tail, up to the free-slot count at cycle start.
REQ-022 Unmatched inputs beyond the free-slot count SHALL see in_accept=0 and SHALL hold their request.
REQ-023 When full (count==DEPTH), allocation SHALL be refused and merges SHALL still be accepted.
REQ-024 A slot freed by a pop SHALL become allocatable from the next cycle only.
REQ-025 Output order SHALL be allocation order, as a circular queue.
REQ-026 Head and tail pointers SHALL wrap from DEPTH-1 to 0; DEPTH need not be a power of 2.
REQ-027 Latency SHALL be one cycle from allocation to out_valid, and one cycle from a merge to the out_src update.
REQ-028 out_* SHALL be driven from registers; out_valid SHALL equal (count!=0).
REQ-029 Pop and allocate in the same cycle: count SHALL change by (allocations - 1).

Reset
REQ-030 rst_n low SHALL immediately clear all entry valids, head=0, tail=0, count=0, out_valid=0, and out_type/addr/dst/src=0.
REQ-031 in_accept and kill SHALL be 0 during reset.
REQ-032 Reset asserted mid-operation SHALL discard all buffered entries; no partial merge SHALL survive.

Structure
REQ-033 Field widths and positions (MEM_ADDR_WIDTH, DST_WIDTH, SRC_LIST_WIDTH, HS/MEM_ADDR/DST/SRC_LIST positions) SHALL come from the shared global.vh.
REQ-034 A combinational sub-module merge_match SHALL compare one input key against all DEPTH entries and return a one-hot lowest-index hit vector.
REQ-035 The top level SHALL instantiate merge_match NUM_PORT times.

Verification
REQ-036 Port0 {type 0, addr 0x40, dst 3, src 0b00001} into an empty queue -> in_accept[0]=1, kill=0; next cycle out_valid=1, out_src=0b00001, count=1.
REQ-037 With that entry held (out_ready=0), port2 sends the same key with src 0b00100 -> kill[2]=1; next cycle out_src=0b00101, count=1.
REQ-038 Same cycle, ports 1 and 3 send an identical new key with src 0b00010 and 0b01000 -> port1 allocates, kill[3]=1; entry src=0b01010.
REQ-039 DEPTH=4 full, out_ready=0; port0 sends a new key and port4 a key matching entry 2 -> in_accept[0]=0, kill[4]=1, count stays 4.
REQ-040 Head popped (out_ready=1) while port1 sends the head key -> no kill; port1 allocates; pops in allocation order across pointer wrap.
REQ-041 rst_n pulled low mid-merge with 3 entries -> count=0 and out_valid=0 immediately; first post-reset request allocates at slot 0.

Source files
------------

// File: rtl/merge_queue_pkg.sv
// Shared widths and helpers for the merge queue.
package merge_queue_pkg;

  localparam int ADDR_WIDTH_DEF = 16;
  localparam int DST_WIDTH_DEF  = 4;
  localparam int SRC_WIDTH_DEF  = 5;

  // Circular pointer advance; step never exceeds depth.
  function automatic int wrap_add(input int base, input int step, input int depth);
    int s;
    s = base + step;
    return (s >= depth) ? s - depth : s;
  endfunction

endpackage

// File: rtl/merge_match.sv
// Compares one request key against every buffered entry.
// Returns a one-hot vector marking the lowest-index matching entry.
module merge_match
  import merge_queue_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = ADDR_WIDTH_DEF,
  parameter int DST_W  = DST_WIDTH_DEF
) (
  input  logic                    key_type,
  input  logic [ADDR_W-1:0]       key_addr,
  input  logic [DST_W-1:0]        key_dst,
  input  logic [DEPTH-1:0]        ent_mask,
  input  logic [DEPTH-1:0]        ent_type,
  input  logic [DEPTH*ADDR_W-1:0] ent_addr,
  input  logic [DEPTH*DST_W-1:0]  ent_dst,
  output logic [DEPTH-1:0]        hit
);

  logic [DEPTH-1:0] raw;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_cmp
      assign raw[gi] = ent_mask[gi]
                    && (ent_type[gi] == key_type)
                    && (ent_addr[gi*ADDR_W +: ADDR_W] == key_addr)
                    && (ent_dst[gi*DST_W +: DST_W] == key_dst);
    end
  endgenerate

  // Isolate the lowest set bit.
  assign hit = raw & (~raw + DEPTH'(1));

endmodule

// File: rtl/merge_queue.sv
// Request queue that folds matching {type, addr, dst} requests into one entry
// by ORing their source lists, and otherwise allocates in arrival order.
module merge_queue
  import merge_queue_pkg::*;
#(
  parameter int NUM_PORT = 5,
  parameter int DEPTH    = 4,
  parameter int ADDR_W   = ADDR_WIDTH_DEF,
  parameter int DST_W    = DST_WIDTH_DEF,
  parameter int SRC_W    = SRC_WIDTH_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_PORT-1:0]         in_valid,
  input  logic [NUM_PORT-1:0]         in_type,
  input  logic [NUM_PORT*ADDR_W-1:0]  in_addr,
  input  logic [NUM_PORT*DST_W-1:0]   in_dst,
  input  logic [NUM_PORT*SRC_W-1:0]   in_src,
  output logic [NUM_PORT-1:0]         in_accept,
  output logic [NUM_PORT-1:0]         kill,
  output logic                        out_valid,
  output logic                        out_type,
  output logic [ADDR_W-1:0]           out_addr,
  output logic [DST_W-1:0]            out_dst,
  output logic [SRC_W-1:0]            out_src,
  input  logic                        out_ready,
  output logic [$clog2(DEPTH+1)-1:0]  count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0]  valid_reg, valid_next;
  logic [DEPTH-1:0]  type_reg, type_next;
  logic [ADDR_W-1:0] addr_reg [DEPTH];
  logic [ADDR_W-1:0] addr_next [DEPTH];
  logic [DST_W-1:0]  dst_reg [DEPTH];
  logic [DST_W-1:0]  dst_next [DEPTH];
  logic [SRC_W-1:0]  src_reg [DEPTH];
  logic [SRC_W-1:0]  src_next [DEPTH];
  logic [PTR_W-1:0]  head_reg, head_next, tail_reg, tail_next;
  logic [CNT_W-1:0]  count_reg, count_next;

  logic              out_valid_reg, out_type_reg;
  logic [ADDR_W-1:0] out_addr_reg;
  logic [DST_W-1:0]  out_dst_reg;
  logic [SRC_W-1:0]  out_src_reg;

  logic                    pop;
  logic [DEPTH-1:0]        head_oh, match_mask;
  logic [DEPTH*ADDR_W-1:0] ent_addr_flat;
  logic [DEPTH*DST_W-1:0]  ent_dst_flat;
  logic [DEPTH-1:0]        hit [NUM_PORT];
  logic [NUM_PORT-1:0]     accept_c, kill_c;

  assign pop     = out_valid_reg && out_ready;
  assign head_oh = {{(DEPTH-1){1'b0}}, 1'b1} << head_reg;
  // A departing head must not absorb new requests.
  assign match_mask = valid_reg & ~(pop ? head_oh : '0);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_flat
      assign ent_addr_flat[gi*ADDR_W +: ADDR_W] = addr_reg[gi];
      assign ent_dst_flat[gi*DST_W +: DST_W]    = dst_reg[gi];
    end
    for (gi = 0; gi < NUM_PORT; gi++) begin : g_match
      merge_match #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DST_W  (DST_W)
      ) u_merge_match (
        .key_type (in_type[gi]),
        .key_addr (in_addr[gi*ADDR_W +: ADDR_W]),
        .key_dst  (in_dst[gi*DST_W +: DST_W]),
        .ent_mask (match_mask),
        .ent_type (type_reg),
        .ent_addr (ent_addr_flat),
        .ent_dst  (ent_dst_flat),
        .hit      (hit[gi])
      );
    end
  endgenerate

  always_comb begin
    int                  rank;
    int                  free_slots;
    int                  ldr [NUM_PORT];
    logic [NUM_PORT-1:0] st_hit, alloc_ok;
    logic [PTR_W-1:0]    slot [NUM_PORT];
    logic                ldr_ok;
    logic [PTR_W-1:0]    ldr_slot;

    rank       = 0;
    free_slots = DEPTH - int'(count_reg);
    valid_next = valid_reg;
    type_next  = type_reg;
    addr_next  = addr_reg;
    dst_next   = dst_reg;
    src_next   = src_reg;
    accept_c   = '0;
    kill_c     = '0;
    alloc_ok   = '0;
    ldr_ok     = 1'b0;
    ldr_slot   = '0;
    if (pop) valid_next[head_reg] = 1'b0;

    for (int p = 0; p < NUM_PORT; p++) begin
      st_hit[p] = in_valid[p] && (hit[p] != '0);
      slot[p]   = '0;
      ldr[p]    = p;
    end

    // Among requests with no stored match, the lowest port with an equal key leads.
    for (int p = 0; p < NUM_PORT; p++) begin
      for (int q = 0; q < NUM_PORT; q++) begin
        if (q < p && ldr[p] == p && in_valid[q] && !st_hit[q]
            && in_type[q] == in_type[p]
            && in_addr[q*ADDR_W +: ADDR_W] == in_addr[p*ADDR_W +: ADDR_W]
            && in_dst[q*DST_W +: DST_W] == in_dst[p*DST_W +: DST_W])
          ldr[p] = q;
      end
    end

    for (int p = 0; p < NUM_PORT; p++) begin
      if (in_valid[p]) begin
        if (st_hit[p]) begin
          accept_c[p] = 1'b1;
          kill_c[p]   = 1'b1;
          for (int e = 0; e < DEPTH; e++)
            if (hit[p][e]) src_next[e] = src_next[e] | in_src[p*SRC_W +: SRC_W];
        end else if (ldr[p] == p) begin
          if (rank < free_slots) begin
            accept_c[p] = 1'b1;
            alloc_ok[p] = 1'b1;
            slot[p]     = PTR_W'(wrap_add(int'(tail_reg), rank, DEPTH));
            rank        = rank + 1;
            valid_next[slot[p]] = 1'b1;
            type_next[slot[p]]  = in_type[p];
            addr_next[slot[p]]  = in_addr[p*ADDR_W +: ADDR_W];
            dst_next[slot[p]]   = in_dst[p*DST_W +: DST_W];
            src_next[slot[p]]   = in_src[p*SRC_W +: SRC_W];
          end
        end else begin
          // Follower rides on its leader's fresh allocation, or waits with it.
          ldr_ok   = 1'b0;
          ldr_slot = '0;
          for (int q = 0; q < NUM_PORT; q++) begin
            if (ldr[p] == q) begin
              ldr_ok   = alloc_ok[q];
              ldr_slot = slot[q];
            end
          end
          if (ldr_ok) begin
            accept_c[p] = 1'b1;
            kill_c[p]   = 1'b1;
            slot[p]     = ldr_slot;
            src_next[ldr_slot] = src_next[ldr_slot] | in_src[p*SRC_W +: SRC_W];
          end
        end
      end
    end

    count_next = CNT_W'(int'(count_reg) + rank - (pop ? 1 : 0));
    tail_next  = PTR_W'(wrap_add(int'(tail_reg), rank, DEPTH));
    head_next  = pop ? PTR_W'(wrap_add(int'(head_reg), 1, DEPTH)) : head_reg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg     <= '0;
      type_reg      <= '0;
      head_reg      <= '0;
      tail_reg      <= '0;
      count_reg     <= '0;
      out_valid_reg <= 1'b0;
      out_type_reg  <= 1'b0;
      out_addr_reg  <= '0;
      out_dst_reg   <= '0;
      out_src_reg   <= '0;
      for (int e = 0; e < DEPTH; e++) begin
        addr_reg[e] <= '0;
        dst_reg[e]  <= '0;
        src_reg[e]  <= '0;
      end
    end else begin
      valid_reg     <= valid_next;
      type_reg      <= type_next;
      addr_reg      <= addr_next;
      dst_reg       <= dst_next;
      src_reg       <= src_next;
      head_reg      <= head_next;
      tail_reg      <= tail_next;
      count_reg     <= count_next;
      out_valid_reg <= (count_next != '0);
      out_type_reg  <= type_next[head_next];
      out_addr_reg  <= addr_next[head_next];
      out_dst_reg   <= dst_next[head_next];
      out_src_reg   <= src_next[head_next];
    end
  end

  assign in_accept = accept_c & {NUM_PORT{rst_n}};
  assign kill      = kill_c & {NUM_PORT{rst_n}};
  assign out_valid = out_valid_reg;
  assign out_type  = out_type_reg;
  assign out_addr  = out_addr_reg;
  assign out_dst   = out_dst_reg;
  assign out_src   = out_src_reg;
  assign count     = count_reg;

endmodule

// File: tb/tb_merge_queue.sv
// Directed bench for merge_queue: allocation, merging, full behaviour,
// pop ordering across pointer wrap and asynchronous reset.
module tb_merge_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  in_valid, in_type;
  logic [79:0] in_addr;
  logic [19:0] in_dst;
  logic [24:0] in_src;
  logic [4:0]  in_accept, kill;
  logic        out_valid, out_type, out_ready;
  logic [15:0] out_addr;
  logic [3:0]  out_dst;
  logic [4:0]  out_src;
  logic [2:0]  count;

  int total = 0;
  int bad   = 0;

  merge_queue #(
    .NUM_PORT (5),
    .DEPTH    (4),
    .ADDR_W   (16),
    .DST_W    (4),
    .SRC_W    (5)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_type   (in_type),
    .in_addr   (in_addr),
    .in_dst    (in_dst),
    .in_src    (in_src),
    .in_accept (in_accept),
    .kill      (kill),
    .out_valid (out_valid),
    .out_type  (out_type),
    .out_addr  (out_addr),
    .out_dst   (out_dst),
    .out_src   (out_src),
    .out_ready (out_ready),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic clear_in();
    in_valid = '0; in_type = '0; in_addr = '0; in_dst = '0; in_src = '0;
  endtask

  task automatic put(input int p, input logic t, input logic [15:0] a,
                     input logic [3:0] d, input logic [4:0] s);
    in_valid[p]        = 1'b1;
    in_type[p]         = t;
    in_addr[p*16 +: 16] = a;
    in_dst[p*4 +: 4]   = d;
    in_src[p*5 +: 5]   = s;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; out_ready = 1'b0; clear_in();
    for (int p = 0; p < 5; p++) put(p, 1'b1, 16'h1234, 4'h5, 5'b11111);
    tick(); tick();
    total++;
    if ({in_accept, kill} !== 10'b0) begin
      bad++; $display("FAIL reset_accept: got acc=%b kill=%b want acc=00000 kill=00000", in_accept, kill);
    end
    total++;
    if ({out_valid, count, out_type, out_addr, out_dst, out_src} !== 30'b0) begin
      bad++; $display("FAIL reset_head: got v=%b cnt=%0d t=%b a=%h d=%h s=%b want all zero",
                      out_valid, count, out_type, out_addr, out_dst, out_src);
    end
    rst_n = 1'b1; clear_in();
    $display("txn reset released");
  endtask

  task automatic test_alloc();
    put(0, 1'b0, 16'h0040, 4'd3, 5'b00001);
    #1;
    total++;
    if ({in_accept, kill} !== {5'b00001, 5'b00000}) begin
      bad++; $display("FAIL alloc_accept: got acc=%b kill=%b want acc=00001 kill=00000", in_accept, kill);
    end
    tick(); clear_in();
    total++;
    if ({out_valid, count, out_type, out_addr, out_dst, out_src} !== {1'b1, 3'd1, 1'b0, 16'h0040, 4'd3, 5'b00001}) begin
      bad++; $display("FAIL alloc_head: got v=%b cnt=%0d t=%b a=%h d=%0d s=%b want v=1 cnt=1 t=0 a=0040 d=3 s=00001",
                      out_valid, count, out_type, out_addr, out_dst, out_src);
    end
    $display("txn alloc port0 key 0/0040/3");
  endtask

  task automatic test_merge();
    put(2, 1'b0, 16'h0040, 4'd3, 5'b00100);
    #1;
    total++;
    if ({in_accept, kill} !== {5'b00100, 5'b00100}) begin
      bad++; $display("FAIL merge_kill: got acc=%b kill=%b want acc=00100 kill=00100", in_accept, kill);
    end
    tick(); clear_in();
    total++;
    if ({out_valid, count, out_src} !== {1'b1, 3'd1, 5'b00101}) begin
      bad++; $display("FAIL merge_head: got v=%b cnt=%0d s=%b want v=1 cnt=1 s=00101", out_valid, count, out_src);
    end
    $display("txn merge port2 into head");
  endtask

  task automatic test_same_cycle();
    put(1, 1'b1, 16'h0080, 4'd5, 5'b00010);
    put(3, 1'b1, 16'h0080, 4'd5, 5'b01000);
    #1;
    total++;
    if ({in_accept, kill} !== {5'b01010, 5'b01000}) begin
      bad++; $display("FAIL same_cycle_kill: got acc=%b kill=%b want acc=01010 kill=01000", in_accept, kill);
    end
    tick(); clear_in();
    total++;
    if ({out_valid, count, out_addr, out_src} !== {1'b1, 3'd2, 16'h0040, 5'b00101}) begin
      bad++; $display("FAIL same_cycle_head: got v=%b cnt=%0d a=%h s=%b want v=1 cnt=2 a=0040 s=00101",
                      out_valid, count, out_addr, out_src);
    end
    $display("txn ports1/3 same key, port1 allocates");
  endtask

  task automatic test_full();
    put(0, 1'b0, 16'h00C0, 4'd1, 5'b00001);
    put(1, 1'b0, 16'h0100, 4'd2, 5'b00010);
    #1;
    total++;
    if ({in_accept, kill} !== {5'b00011, 5'b00000}) begin
      bad++; $display("FAIL fill_accept: got acc=%b kill=%b want acc=00011 kill=00000", in_accept, kill);
    end
    tick(); clear_in();
    total++;
    if ({out_valid, count, out_src} !== {1'b1, 3'd4, 5'b00101}) begin
      bad++; $display("FAIL fill_head: got v=%b cnt=%0d s=%b want v=1 cnt=4 s=00101", out_valid, count, out_src);
    end
    put(0, 1'b1, 16'h0200, 4'd7, 5'b10000);
    put(3, 1'b0, 16'h00C0, 4'd1, 5'b01000);
    put(4, 1'b0, 16'h00C0, 4'd1, 5'b10000);
    #1;
    total++;
    if ({in_accept, kill} !== {5'b11000, 5'b11000}) begin
      bad++; $display("FAIL full_merge: got acc=%b kill=%b want acc=11000 kill=11000", in_accept, kill);
    end
    tick();
    total++;
    if (in_accept[0] !== 1'b0) begin
      bad++; $display("FAIL full_hold: got acc0=%b want acc0=0", in_accept[0]);
    end
    clear_in();
    total++;
    if ({out_valid, count, out_addr, out_src} !== {1'b1, 3'd4, 16'h0040, 5'b00101}) begin
      bad++; $display("FAIL full_head: got v=%b cnt=%0d a=%h s=%b want v=1 cnt=4 a=0040 s=00101",
                      out_valid, count, out_addr, out_src);
    end
    $display("txn full: port0 refused, ports3/4 merged into entry 2");
  endtask

  task automatic test_pop_wrap();
    out_ready = 1'b1;
    put(1, 1'b0, 16'h0040, 4'd3, 5'b00010);
    #1;
    total++;
    if ({in_accept, kill} !== 10'b0) begin
      bad++; $display("FAIL pop_head_excluded: got acc=%b kill=%b want acc=00000 kill=00000", in_accept, kill);
    end
    tick();
    total++;
    if ({out_valid, count, out_type, out_addr, out_dst, out_src} !== {1'b1, 3'd3, 1'b1, 16'h0080, 4'd5, 5'b01010}) begin
      bad++; $display("FAIL pop_first: got v=%b cnt=%0d t=%b a=%h d=%0d s=%b want v=1 cnt=3 t=1 a=0080 d=5 s=01010",
                      out_valid, count, out_type, out_addr, out_dst, out_src);
    end
    #1;
    total++;
    if ({in_accept, kill} !== {5'b00010, 5'b00000}) begin
      bad++; $display("FAIL pop_alloc_wrap: got acc=%b kill=%b want acc=00010 kill=00000", in_accept, kill);
    end
    tick(); clear_in();
    total++;
    if ({out_valid, count, out_addr, out_dst, out_src} !== {1'b1, 3'd3, 16'h00C0, 4'd1, 5'b11001}) begin
      bad++; $display("FAIL pop_second: got v=%b cnt=%0d a=%h d=%0d s=%b want v=1 cnt=3 a=00c0 d=1 s=11001",
                      out_valid, count, out_addr, out_dst, out_src);
    end
    tick();
    total++;
    if ({out_valid, count, out_addr, out_dst, out_src} !== {1'b1, 3'd2, 16'h0100, 4'd2, 5'b00010}) begin
      bad++; $display("FAIL pop_third: got v=%b cnt=%0d a=%h d=%0d s=%b want v=1 cnt=2 a=0100 d=2 s=00010",
                      out_valid, count, out_addr, out_dst, out_src);
    end
    tick();
    total++;
    if ({out_valid, count, out_type, out_addr, out_dst, out_src} !== {1'b1, 3'd1, 1'b0, 16'h0040, 4'd3, 5'b00010}) begin
      bad++; $display("FAIL pop_wrapped: got v=%b cnt=%0d t=%b a=%h d=%0d s=%b want v=1 cnt=1 t=0 a=0040 d=3 s=00010",
                      out_valid, count, out_type, out_addr, out_dst, out_src);
    end
    tick();
    total++;
    if ({out_valid, count} !== {1'b0, 3'd0}) begin
      bad++; $display("FAIL pop_empty: got v=%b cnt=%0d want v=0 cnt=0", out_valid, count);
    end
    out_ready = 1'b0;
    $display("txn drained in allocation order across wrap");
  endtask

  task automatic test_reset_mid();
    put(0, 1'b0, 16'h0010, 4'd1, 5'b00001);
    put(1, 1'b0, 16'h0020, 4'd2, 5'b00010);
    put(2, 1'b0, 16'h0030, 4'd3, 5'b00100);
    #1;
    total++;
    if ({in_accept, kill} !== {5'b00111, 5'b00000}) begin
      bad++; $display("FAIL mid_fill: got acc=%b kill=%b want acc=00111 kill=00000", in_accept, kill);
    end
    tick(); clear_in();
    total++;
    if ({out_valid, count, out_addr, out_src} !== {1'b1, 3'd3, 16'h0010, 5'b00001}) begin
      bad++; $display("FAIL mid_head: got v=%b cnt=%0d a=%h s=%b want v=1 cnt=3 a=0010 s=00001",
                      out_valid, count, out_addr, out_src);
    end
    put(3, 1'b0, 16'h0020, 4'd2, 5'b01000);
    #1;
    total++;
    if (kill !== 5'b01000) begin
      bad++; $display("FAIL mid_merge_kill: got kill=%b want kill=01000", kill);
    end
    #1 rst_n = 1'b0;
    #1;
    total++;
    if ({out_valid, count, in_accept, kill, out_type, out_addr, out_dst, out_src} !== 40'b0) begin
      bad++; $display("FAIL mid_reset_clear: got v=%b cnt=%0d acc=%b kill=%b a=%h s=%b want all zero",
                      out_valid, count, in_accept, kill, out_addr, out_src);
    end
    tick();
    rst_n = 1'b1; clear_in();
    put(0, 1'b0, 16'h0020, 4'd2, 5'b00100);
    #1;
    total++;
    if ({in_accept, kill} !== {5'b00001, 5'b00000}) begin
      bad++; $display("FAIL post_reset_accept: got acc=%b kill=%b want acc=00001 kill=00000", in_accept, kill);
    end
    tick(); clear_in();
    total++;
    if ({out_valid, count, out_addr, out_dst, out_src} !== {1'b1, 3'd1, 16'h0020, 4'd2, 5'b00100}) begin
      bad++; $display("FAIL post_reset_head: got v=%b cnt=%0d a=%h d=%0d s=%b want v=1 cnt=1 a=0020 d=2 s=00100",
                      out_valid, count, out_addr, out_dst, out_src);
    end
    $display("txn reset mid-merge, fresh allocation afterwards");
  endtask

  initial begin
    test_reset();
    test_alloc();
    test_merge();
    test_same_cycle();
    test_full();
    test_pop_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
